id_ex_stage: RTL and testbench

- ID/EX pipeline register sitting directly upstream of the EX-stage ALU.
- Captures decoded operands, opcode and writeback control each cycle.
- Supports stall (hold) and flush (bubble).
- Resolves RAW hazards by forwarding EX/MEM and MEM/WB results onto the ALU operand outputs.

---
 rtl/id_ex_pkg.sv | 29 ++
 rtl/id_ex_fwd_mux.sv | 22 ++
 rtl/id_ex_stage.sv | 70 +++++++
 tb/tb_id_ex_stage.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/id_ex_pkg.sv
// id_ex_pkg: shared widths, ALU opcodes, forward-select encodings and the bubble value for the ID/EX stage
package id_ex_pkg;
  localparam int n = 32;
  localparam int ADDR_W = 3;
  typedef enum logic [2:0] {
    OP_MOV  = 3'b000,
    OP_NOT  = 3'b001,
    OP_AND  = 3'b010,
    OP_ADD  = 3'b011,
    OP_NOR  = 3'b100,
    OP_NAND = 3'b101,
    OP_SUB  = 3'b110,
    OP_SLT  = 3'b111
  } alu_op_e;
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  typedef struct packed {
    logic              valid;
    logic [2:0]        op;
    logic [n-1:0]      r2;
    logic [n-1:0]      r3;
    logic [ADDR_W-1:0] src2;
    logic [ADDR_W-1:0] src3;
    logic [ADDR_W-1:0] dst;
    logic              we;
  } idex_t;
  localparam idex_t BUBBLE = '0;
endpackage

// File: rtl/id_ex_fwd_mux.sv
// id_ex_fwd_mux: per-operand bypass select; the newer EX/MEM result beats MEM/WB, register 0 included
module id_ex_fwd_mux
  import id_ex_pkg::*;
(
  input  logic [ADDR_W-1:0] src,
  input  logic [n-1:0]      reg_data,
  input  logic              exmem_we,
  input  logic [ADDR_W-1:0] exmem_dst,
  input  logic [n-1:0]      exmem_data,
  input  logic              memwb_we,
  input  logic [ADDR_W-1:0] memwb_dst,
  input  logic [n-1:0]      memwb_data,
  output logic [n-1:0]      operand,
  output logic [1:0]        sel
);
  always_comb begin
    sel = (exmem_we && exmem_dst == src) ? FWD_EXMEM :
          (memwb_we && memwb_dst == src) ? FWD_MEMWB : FWD_REG;
    operand = (sel == FWD_EXMEM) ? exmem_data :
              (sel == FWD_MEMWB) ? memwb_data : reg_data;
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with stall/flush; operand forwarding only when IDEX_FWD_EN is defined
module id_ex_stage
  import id_ex_pkg::*;
(
  input  logic              IDEX_CLK,
  input  logic              IDEX_RST_N,
  input  logic              IDEX_STALL,
  input  logic              IDEX_FLUSH,
  input  logic              IDEX_IN_VALID,
  input  logic [2:0]        IDEX_IN_ALUOP,
  input  logic [n-1:0]      IDEX_IN_R2,
  input  logic [n-1:0]      IDEX_IN_R3,
  input  logic [ADDR_W-1:0] IDEX_IN_SRC2,
  input  logic [ADDR_W-1:0] IDEX_IN_SRC3,
  input  logic [ADDR_W-1:0] IDEX_IN_DST,
  input  logic              IDEX_IN_WE,
  input  logic              IDEX_EXMEM_WE,
  input  logic [ADDR_W-1:0] IDEX_EXMEM_DST,
  input  logic [n-1:0]      IDEX_EXMEM_DATA,
  input  logic              IDEX_MEMWB_WE,
  input  logic [ADDR_W-1:0] IDEX_MEMWB_DST,
  input  logic [n-1:0]      IDEX_MEMWB_DATA,
  output logic [n-1:0]      IDEX_ALU_R2,
  output logic [n-1:0]      IDEX_ALU_R3,
  output logic [2:0]        IDEX_ALU_ALUOP,
  output logic              IDEX_OUT_VALID,
  output logic [ADDR_W-1:0] IDEX_OUT_DST,
  output logic              IDEX_OUT_WE,
  output logic [1:0]        IDEX_FWD2,
  output logic [1:0]        IDEX_FWD3
);
  idex_t cur_q, cur_d;
  always_comb begin
    cur_d = IDEX_FLUSH ? BUBBLE :
            IDEX_STALL ? cur_q :
            '{valid: IDEX_IN_VALID, op: IDEX_IN_ALUOP, r2: IDEX_IN_R2, r3: IDEX_IN_R3,
              src2: IDEX_IN_SRC2, src3: IDEX_IN_SRC3, dst: IDEX_IN_DST,
              we: IDEX_IN_WE & IDEX_IN_VALID};
  end
  always_ff @(posedge IDEX_CLK or negedge IDEX_RST_N) begin
    if (!IDEX_RST_N) cur_q <= BUBBLE;
    else cur_q <= cur_d;
  end
  assign IDEX_ALU_ALUOP = cur_q.op;
  assign IDEX_OUT_VALID = cur_q.valid;
  assign IDEX_OUT_DST   = cur_q.dst;
  assign IDEX_OUT_WE    = cur_q.we;
`ifdef IDEX_FWD_EN
  id_ex_fwd_mux u_fwd2 (
    .src(cur_q.src2), .reg_data(cur_q.r2),
    .exmem_we(IDEX_EXMEM_WE), .exmem_dst(IDEX_EXMEM_DST), .exmem_data(IDEX_EXMEM_DATA),
    .memwb_we(IDEX_MEMWB_WE), .memwb_dst(IDEX_MEMWB_DST), .memwb_data(IDEX_MEMWB_DATA),
    .operand(IDEX_ALU_R2), .sel(IDEX_FWD2)
  );
  id_ex_fwd_mux u_fwd3 (
    .src(cur_q.src3), .reg_data(cur_q.r3),
    .exmem_we(IDEX_EXMEM_WE), .exmem_dst(IDEX_EXMEM_DST), .exmem_data(IDEX_EXMEM_DATA),
    .memwb_we(IDEX_MEMWB_WE), .memwb_dst(IDEX_MEMWB_DST), .memwb_data(IDEX_MEMWB_DATA),
    .operand(IDEX_ALU_R3), .sel(IDEX_FWD3)
  );
`else
  logic unused_fwd;
  assign unused_fwd = ^{IDEX_EXMEM_WE, IDEX_EXMEM_DST, IDEX_EXMEM_DATA,
                        IDEX_MEMWB_WE, IDEX_MEMWB_DST, IDEX_MEMWB_DATA, cur_q.src2, cur_q.src3};
  assign IDEX_ALU_R2 = cur_q.r2;
  assign IDEX_ALU_R3 = cur_q.r3;
  assign IDEX_FWD2   = FWD_REG;
  assign IDEX_FWD3   = FWD_REG;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: vector table, directed corner sequences and random stimulus against a transaction-level model
module tb_id_ex_stage;
`ifdef IDEX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  typedef struct packed {
    logic stall, flush, valid;
    logic [2:0] op;
    logic [31:0] r2, r3;
    logic [2:0] s2, s3, dst;
    logic we, ex_we;
    logic [2:0] ex_dst;
    logic [31:0] ex_data;
    logic mw_we;
    logic [2:0] mw_dst;
    logic [31:0] mw_data;
  } vin_t;
  typedef struct packed {
    logic valid;
    logic [2:0] op;
    logic [31:0] r2, r3;
    logic [2:0] s2, s3, dst;
    logic we;
  } inst_t;
  typedef struct packed {
    logic [31:0] r2, r3;
    logic [2:0] op;
    logic valid;
    logic [2:0] dst;
    logic we;
    logic [1:0] f2, f3;
  } out_t;
  typedef struct packed {
    vin_t in;
    out_t exp;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b1;
  logic stall, flush, in_valid, in_we, ex_we, mw_we, valid_o, we_o;
  logic [2:0] in_op, s2, s3, dst, ex_dst, mw_dst, op_o, dst_o;
  logic [31:0] in_r2, in_r3, ex_data, mw_data, r2_o, r3_o;
  logic [1:0] f2_o, f3_o;
  int checks = 0, failures = 0;
  inst_t m;
  vec_t tab[7];
  always #5 clk = ~clk;
  id_ex_stage dut (
    .IDEX_CLK(clk), .IDEX_RST_N(rst_n), .IDEX_STALL(stall), .IDEX_FLUSH(flush),
    .IDEX_IN_VALID(in_valid), .IDEX_IN_ALUOP(in_op), .IDEX_IN_R2(in_r2), .IDEX_IN_R3(in_r3),
    .IDEX_IN_SRC2(s2), .IDEX_IN_SRC3(s3), .IDEX_IN_DST(dst), .IDEX_IN_WE(in_we),
    .IDEX_EXMEM_WE(ex_we), .IDEX_EXMEM_DST(ex_dst), .IDEX_EXMEM_DATA(ex_data),
    .IDEX_MEMWB_WE(mw_we), .IDEX_MEMWB_DST(mw_dst), .IDEX_MEMWB_DATA(mw_data),
    .IDEX_ALU_R2(r2_o), .IDEX_ALU_R3(r3_o), .IDEX_ALU_ALUOP(op_o), .IDEX_OUT_VALID(valid_o),
    .IDEX_OUT_DST(dst_o), .IDEX_OUT_WE(we_o), .IDEX_FWD2(f2_o), .IDEX_FWD3(f3_o)
  );
  function automatic vin_t mk(logic st, logic fl, logic v, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                              logic [2:0] d, logic w);
    vin_t x = '0;
    x.stall = st; x.flush = fl; x.valid = v; x.op = op; x.r2 = a; x.r3 = b;
    x.s2 = 3'd1; x.s3 = 3'd2; x.dst = d; x.we = w;
    return x;
  endfunction
  function automatic out_t mo(logic [31:0] a, logic [31:0] b, logic [2:0] op, logic v, logic [2:0] d, logic w);
    out_t o = '0;
    o.r2 = a; o.r3 = b; o.op = op; o.valid = v; o.dst = d; o.we = w;
    return o;
  endfunction
  function automatic logic [33:0] pick(logic [2:0] s, logic [31:0] d, vin_t v);
    if (FWD && v.ex_we && v.ex_dst == s) return {v.ex_data, 2'b10};
    if (FWD && v.mw_we && v.mw_dst == s) return {v.mw_data, 2'b01};
    return {d, 2'b00};
  endfunction
  function automatic out_t model_out(inst_t x, vin_t v);
    out_t o = mo(x.r2, x.r3, x.op, x.valid, x.dst, x.we);
    {o.r2, o.f2} = pick(x.s2, x.r2, v);
    {o.r3, o.f3} = pick(x.s3, x.r3, v);
    return o;
  endfunction
  function automatic out_t dut_out();
    return '{r2: r2_o, r3: r3_o, op: op_o, valid: valid_o, dst: dst_o, we: we_o, f2: f2_o, f3: f3_o};
  endfunction
  task automatic drive(input vin_t v);
    stall = v.stall; flush = v.flush; in_valid = v.valid; in_op = v.op; in_r2 = v.r2; in_r3 = v.r3;
    s2 = v.s2; s3 = v.s3; dst = v.dst; in_we = v.we;
    ex_we = v.ex_we; ex_dst = v.ex_dst; ex_data = v.ex_data;
    mw_we = v.mw_we; mw_dst = v.mw_dst; mw_data = v.mw_data;
  endtask
  task automatic cycle(input vin_t v);
    drive(v);
    @(posedge clk);
    if (v.flush) m = '0;
    else if (!v.stall) m = '{valid: v.valid, op: v.op, r2: v.r2, r3: v.r3, s2: v.s2, s3: v.s3,
                             dst: v.dst, we: v.we & v.valid};
    @(negedge clk);
  endtask
  task automatic check(input string name, input out_t exp);
    out_t got = dut_out();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  initial begin
    vin_t v;
    drive(mk(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 3'd0, 1'b0));
    m = '0;
    #1 rst_n = 1'b0;
    #1 check("reset_async", '0);
    @(negedge clk) rst_n = 1'b1;
    tab[0] = '{mk(0, 0, 1, 3'b011, 32'd5, 32'd7, 3'd3, 1), mo(32'd5, 32'd7, 3'b011, 1, 3'd3, 1)};
    tab[1] = '{mk(0, 0, 0, 3'b010, 32'd9, 32'hA, 3'd4, 1), mo(32'd9, 32'hA, 3'b010, 0, 3'd4, 0)};
    tab[2] = '{mk(1, 0, 1, 3'b111, 32'd1, 32'd2, 3'd6, 1), mo(32'd9, 32'hA, 3'b010, 0, 3'd4, 0)};
    tab[3] = '{mk(0, 0, 1, 3'b110, 32'hFFFF_FFFF, 32'd1, 3'd7, 0), mo(32'hFFFF_FFFF, 32'd1, 3'b110, 1, 3'd7, 0)};
    tab[4] = '{mk(1, 1, 1, 3'b101, 32'd3, 32'd4, 3'd2, 1), mo(32'd0, 32'd0, 3'b000, 0, 3'd0, 0)};
    tab[5] = '{mk(0, 0, 1, 3'b001, 32'd8, 32'd8, 3'd1, 1), mo(32'd8, 32'd8, 3'b001, 1, 3'd1, 1)};
    tab[6] = '{mk(0, 1, 1, 3'b100, 32'd6, 32'd6, 3'd5, 1), mo(32'd0, 32'd0, 3'b000, 0, 3'd0, 0)};
    for (int i = 0; i < 7; i++) begin
      cycle(tab[i].in);
      check($sformatf("vec%0d", i), tab[i].exp);
    end
    v = mk(0, 0, 1, 3'b011, 32'd1, 32'd2, 3'd3, 1);
    v.s2 = 3'd2; v.s3 = 3'd6;
    cycle(v);
    stall = 1'b1;
    ex_we = 1'b1; ex_dst = 3'd2; ex_data = 32'hAA;
    mw_we = 1'b1; mw_dst = 3'd2; mw_data = 32'hBB;
    #1 chk32("dbl_r2", r2_o, FWD ? 32'hAA : 32'h1);
    chk32("dbl_f2", {30'd0, f2_o}, FWD ? 32'd2 : 32'd0);
    ex_we = 1'b0;
    #1 chk32("mw_r2", r2_o, FWD ? 32'hBB : 32'h1);
    chk32("mw_f2", {30'd0, f2_o}, FWD ? 32'd1 : 32'd0);
    chk32("mw_r3", r3_o, 32'd2);
    v = mk(0, 0, 1, 3'b101, 32'h11, 32'h33, 3'd1, 1);
    v.s3 = 3'd4;
    cycle(v);
    for (int i = 0; i < 3; i++) begin
      vin_t w = mk(1, 0, 1, 3'(i), 32'(i + 100), 32'(i + 200), 3'd7, 0);
      if (i == 1) begin
        w.mw_we = 1'b1; w.mw_dst = 3'd4; w.mw_data = 32'h55;
      end
      cycle(w);
      chk32($sformatf("stall_r3_%0d", i), r3_o, (FWD && i == 1) ? 32'h55 : 32'h33);
      check($sformatf("stall_hold_%0d", i), model_out(m, w));
      chk32($sformatf("stall_op_%0d", i), {29'd0, op_o}, 32'd5);
    end
    stall = 1'b1; flush = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("reset_mid_stall", '0);
    @(negedge clk) rst_n = 1'b1;
    flush = 1'b0;
    m = '0;
    for (int i = 0; i < 400; i++) begin
      v = '0;
      v.stall = ($urandom % 4) == 0; v.flush = ($urandom % 10) == 0;
      v.valid = 1'($urandom); v.op = 3'($urandom); v.r2 = $urandom; v.r3 = $urandom;
      v.s2 = 3'($urandom); v.s3 = 3'($urandom); v.dst = 3'($urandom); v.we = 1'($urandom);
      v.ex_we = 1'($urandom); v.ex_dst = 3'($urandom); v.ex_data = $urandom;
      v.mw_we = 1'($urandom); v.mw_dst = 3'($urandom); v.mw_data = $urandom;
      cycle(v);
      check($sformatf("rand%0d", i), model_out(m, v));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
